usb_bulk_packetiser: RTL and testbench

Sits between a byte-stream producer (e.g. the loop-back/data FIFO) and the ULPI core's bulk-IN AXI-Stream sink, adding USB packet boundaries. Bytes pass through a one-entry hold register so `tlast` can be attached to a byte after the fact. A packet closes on an upstream `tlast`, on reaching the max packet size for the bus speed, on an idle timeout, or on a flush request. This lets partial packets reach the host without upstream framing logic.

---
 rtl/usb_bulk_packetiser_pkg.sv | 15 +
 rtl/packetiser_hold.sv | 91 +++++++++
 rtl/usb_bulk_packetiser.sv | 107 ++++++++++
 tb/tb_usb_bulk_packetiser.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_bulk_packetiser_pkg.sv
// Shared constants and hold-register payload for the USB bulk-IN packetiser.
package usb_bulk_packetiser_pkg;

    localparam int unsigned USB_MAX_PKT_HS      = 512;
    localparam int unsigned USB_MAX_PKT_FS      = 64;
    localparam int unsigned USB_TIMEOUT_DEFAULT = 4096;
    localparam int unsigned CNT_W               = 10;
    localparam int unsigned PKT_CNT_W           = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } hold_entry_t;

endpackage

// File: rtl/packetiser_hold.sv
// One-entry hold register with release/tlast latch; tlast is decided when the
// byte leaves HOLD, so a byte can be closed after it has been accepted.
module packetiser_hold
    import usb_bulk_packetiser_pkg::*;
(
    input  logic       clock,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready_c,
    input  logic       in_last,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] out_data,
    input  logic       close_c,
    output logic       busy,
    output logic       holding_c,
    output logic       accept_c,
    output logic       emit_c
);

    // bit 0 = hold register valid, bit 1 = released
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_HOLD  = 2'b01;
    localparam logic [1:0] ST_REL   = 2'b11;

    logic [1:0]  state_q, state_d;
    hold_entry_t h_q, h_d;
    logic        tlast_q, tlast_d;
    logic        run_q;

    assign busy       = state_q[0];
    assign out_valid  = state_q[1];
    assign out_last   = tlast_q;
    assign out_data   = h_q.data;
    assign holding_c  = (state_q == ST_HOLD);
    assign in_ready_c = run_q & (~state_q[0] | (state_q[1] & out_ready));
    assign accept_c   = in_valid & in_ready_c;
    assign emit_c     = state_q[1] & out_ready;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            h_q     <= '0;
            tlast_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            tlast_q <= tlast_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        tlast_d = tlast_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    state_d   = ST_HOLD;
                    h_d.data  = in_data;
                    h_d.last  = in_last;
                end
            end
            ST_HOLD: begin
                // a waiting input byte releases without closing the packet
                if (in_valid || close_c || h_q.last) begin
                    state_d = ST_REL;
                    tlast_d = close_c | h_q.last;
                end
            end
            ST_REL: begin
                if (out_ready) begin
                    tlast_d = 1'b0;
                    if (accept_c) begin
                        state_d  = ST_HOLD;
                        h_d.data = in_data;
                        h_d.last = in_last;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

endmodule

// File: rtl/usb_bulk_packetiser.sv
// Adds USB bulk-IN packet boundaries to a byte stream: closes on upstream
// tlast, max packet size, idle timeout or flush request.
module usb_bulk_packetiser
    import usb_bulk_packetiser_pkg::*;
#(
    parameter int unsigned MAX_PKT_HS = USB_MAX_PKT_HS,
    parameter int unsigned MAX_PKT_FS = USB_MAX_PKT_FS,
    parameter int unsigned TIMEOUT    = USB_TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        hs_enabled_i,
    input  logic        flush_i,
    input  logic        s_axis_tvalid_i,
    output logic        s_axis_tready_o,
    input  logic        s_axis_tlast_i,
    input  logic [7:0]  s_axis_tdata_i,
    output logic        m_axis_tvalid_o,
    input  logic        m_axis_tready_i,
    output logic        m_axis_tlast_o,
    output logic [7:0]  m_axis_tdata_o,
    output logic [15:0] pkt_count_o,
    output logic        busy_o
);

    localparam int unsigned       TMR_W   = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  LIM_HS  = CNT_W'(MAX_PKT_HS);
    localparam logic [CNT_W-1:0]  LIM_FS  = CNT_W'(MAX_PKT_FS);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     lim_q, lim_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 flush_q, flush_d;
    logic [PKT_CNT_W-1:0] pkt_q, pkt_d;
    logic                 close_c, holding_c, accept_c, emit_c, busy;

    assign close_c     = (cnt_q == lim_q - CNT_W'(1)) | (tmr_q == TMR_MAX) | flush_q;
    assign pkt_count_o = pkt_q;
    assign busy_o      = busy;

    packetiser_hold u_hold (
        .clock      (clock),
        .rst_n      (rst_n),
        .in_valid   (s_axis_tvalid_i),
        .in_ready_c (s_axis_tready_o),
        .in_last    (s_axis_tlast_i),
        .in_data    (s_axis_tdata_i),
        .out_valid  (m_axis_tvalid_o),
        .out_ready  (m_axis_tready_i),
        .out_last   (m_axis_tlast_o),
        .out_data   (m_axis_tdata_o),
        .close_c    (close_c),
        .busy       (busy),
        .holding_c  (holding_c),
        .accept_c   (accept_c),
        .emit_c     (emit_c)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            lim_q   <= LIM_HS;
            tmr_q   <= '0;
            flush_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            tmr_q   <= tmr_d;
            flush_q <= flush_d;
            pkt_q   <= pkt_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        tmr_d   = tmr_q;
        flush_d = flush_q;
        pkt_d   = pkt_q;
        if (emit_c) begin
            if (m_axis_tlast_o) begin
                cnt_d = '0;
                pkt_d = pkt_q + PKT_CNT_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // the limit follows the bus speed at the first byte of each packet
        if (accept_c && cnt_d == '0) begin
            lim_d = hs_enabled_i ? LIM_HS : LIM_FS;
        end
        if (accept_c) begin
            tmr_d = '0;
        end else if (holding_c && !s_axis_tvalid_i && tmr_q != TMR_MAX) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
        if (flush_i && busy) begin
            flush_d = 1'b1;
        end
        if (emit_c && m_axis_tlast_o) begin
            flush_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_bulk_packetiser.sv
// Randomized bench for usb_bulk_packetiser with a packet-boundary reference model.
`timescale 1ns/1ps
module tb_usb_bulk_packetiser;

    localparam int TO    = 4096;
    localparam int BOUND = 2 * TO + 200;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        hs = 1'b1;
    logic        flush = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        m_ready = 1'b1;
    logic        s_ready, m_valid, m_last, busy;
    logic [7:0]  m_data;
    logic [15:0] pkt_count;

    usb_bulk_packetiser #(.MAX_PKT_HS(512), .MAX_PKT_FS(64), .TIMEOUT(TO)) dut (
        .clock           (clock),
        .rst_n           (rst_n),
        .hs_enabled_i    (hs),
        .flush_i         (flush),
        .s_axis_tvalid_i (s_valid),
        .s_axis_tready_o (s_ready),
        .s_axis_tlast_i  (s_last),
        .s_axis_tdata_i  (s_data),
        .m_axis_tvalid_o (m_valid),
        .m_axis_tready_i (m_ready),
        .m_axis_tlast_o  (m_last),
        .m_axis_tdata_o  (m_data),
        .pkt_count_o     (pkt_count),
        .busy_o          (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int fails = 0;
    int exp_pkts = 0;
    int acc_cyc = 0;

    logic [8:0] out_q[$];
    int         out_cyc[$];
    logic [7:0] in_data[$];
    bit         in_last[$];
    logic [8:0] exp_q[$];

    // sink-side monitor: every completed output handshake
    always @(negedge clock) begin
        if (rst_n && m_valid && m_ready) begin
            out_q.push_back({m_last, m_data});
            out_cyc.push_back(cyc);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clock);
        while (!s_ready && n < BOUND) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!s_ready) begin
            fails++;
            $display("FAIL send_bound: input not accepted after %0d cycles, want accept", n);
        end else begin
            @(posedge clock);
            #1;
            acc_cyc = cyc;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic prep_stream(input int n, input int unsigned odds);
        in_data.delete();
        in_last.delete();
        out_q.delete();
        out_cyc.delete();
        for (int i = 0; i < n; i++) begin
            in_data.push_back(8'($urandom));
            in_last.push_back(odds != 0 && $urandom_range(0, odds - 1) == 0);
        end
    endtask

    task automatic drive_stream();
        for (int i = 0; i < in_data.size(); i++) send_byte(in_data[i], in_last[i]);
    endtask

    // Packet rule: close on upstream last, on the lim-th byte, or on the final byte
    // of a stream followed by a long idle gap.
    function automatic void build_model(input bit hs_sel);
        int lim = hs_sel ? 512 : 64;
        int pos = 0;
        bit lst;
        exp_q.delete();
        for (int i = 0; i < in_data.size(); i++) begin
            pos++;
            lst = in_last[i] || pos == lim || i == in_data.size() - 1;
            exp_q.push_back({lst, in_data[i]});
            if (lst) begin
                pos = 0;
                exp_pkts++;
            end
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(3);
        checks++;
        if ({s_ready, m_valid, m_last, busy} !== 4'b0000 || m_data !== 8'h00 || pkt_count !== 16'h0) begin
            fails++;
            $display("FAIL reset_values: ready=%0b valid=%0b last=%0b busy=%0b data=%02h pkts=%0d, want all 0",
                     s_ready, m_valid, m_last, busy, m_data, pkt_count);
        end
        @(negedge clock);
        rst_n = 1'b1;
        wait_cycles(1);
        checks++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: s_ready=%0b after reset release, want 1", s_ready);
        end
    endtask

    task automatic test_hs_stream();
        int nl = 0;
        hs = 1'b1;
        prep_stream(1024, 0);
        build_model(1'b1);
        drive_stream();
        wait_cycles(50);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL hs_len: got %0d bytes, want %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i][8]) nl++;
            if (out_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL hs_byte %0d: got %03h want %03h", i + 1, out_q[i], exp_q[i]);
            end
        end
        checks++;
        if (nl != 2 || pkt_count !== 16'(exp_pkts)) begin
            fails++;
            $display("FAIL hs_pkts: tlasts=%0d pkt_count=%0d, want 2 and %0d", nl, pkt_count, exp_pkts);
        end
    endtask

    task automatic test_fs_stream();
        hs = 1'b0;
        prep_stream(100, 0);
        build_model(1'b0);
        drive_stream();
        wait_cycles(TO + 20);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL fs_len: got %0d bytes, want %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL fs_byte %0d: got %03h want %03h", i + 1, out_q[i], exp_q[i]);
            end
        end
        if (out_cyc.size() == 100) begin
            checks++;
            if (out_cyc[99] - acc_cyc != TO) begin
                fails++;
                $display("FAIL fs_timeout_latency: got %0d cycles, want %0d", out_cyc[99] - acc_cyc, TO);
            end
        end
        checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            fails++;
            $display("FAIL fs_pkts: got %0d want %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_upstream_last();
        hs = 1'($urandom);
        prep_stream(5, 0);
        in_last[4] = 1'b1;
        build_model(hs);
        drive_stream();
        wait_cycles(20);
        checks++;
        if (out_q.size() != 5) begin
            fails++;
            $display("FAIL last_len: got %0d bytes, want 5", out_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL last_byte %0d: got %03h want %03h", i + 1, out_q[i], exp_q[i]);
            end
        end
        if (out_cyc.size() == 5) begin
            checks++;
            if (out_cyc[4] - acc_cyc != 1) begin
                fails++;
                $display("FAIL last_latency: got %0d cycles, want 1", out_cyc[4] - acc_cyc);
            end
        end
    endtask

    task automatic test_flush();
        int fcyc;
        hs = 1'b1;
        prep_stream(3, 0);
        build_model(1'b1);
        drive_stream();
        wait_cycles(10);
        checks++;
        if (out_q.size() != 2 || busy !== 1'b1) begin
            fails++;
            $display("FAIL flush_pre: got %0d bytes busy=%0b, want 2 bytes busy=1", out_q.size(), busy);
        end
        flush = 1'b1;
        wait_cycles(1);
        fcyc  = cyc;
        flush = 1'b0;
        wait_cycles(5);
        checks++;
        if (out_q.size() != 3) begin
            fails++;
            $display("FAIL flush_len: got %0d bytes, want 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL flush_byte %0d: got %03h want %03h", i + 1, out_q[i], exp_q[i]);
                end
            end
            checks++;
            if (out_cyc[2] - fcyc > 1) begin
                fails++;
                $display("FAIL flush_latency: got %0d cycles after flush edge, want <=1", out_cyc[2] - fcyc);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] a, b;
        a = 8'($urandom);
        b = 8'($urandom);
        hs = 1'b1;
        m_ready = 1'b0;
        out_q.delete();
        send_byte(a, 1'b0);
        fork
            send_byte(b, 1'b0);
            begin
                wait_cycles(3);
                for (int i = 0; i < TO + 50; i++) begin
                    wait_cycles(1);
                    flush = (i == 10);
                    checks++;
                    if (m_valid !== 1'b1 || m_data !== a || m_last !== 1'b0) begin
                        fails++;
                        $display("FAIL stall_freeze cycle %0d: valid=%0b data=%02h last=%0b, want 1 %02h 0",
                                 i, m_valid, m_data, m_last, a);
                    end
                end
                flush = 1'b0;
                m_ready = 1'b1;
            end
        join
        wait_cycles(10);
        exp_pkts++;
        checks++;
        if (out_q.size() != 2 || out_q[0] !== {1'b0, a} || out_q[1] !== {1'b1, b}) begin
            fails++;
            $display("FAIL stall_out: got %0d bytes first=%03h second=%03h, want %03h %03h",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 9'h0, out_q.size() > 1 ? out_q[1] : 9'h0,
                     {1'b0, a}, {1'b1, b});
        end
        checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            fails++;
            $display("FAIL stall_pkts: got %0d want %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_flush_empty();
        logic [7:0] c;
        c = 8'($urandom);
        m_ready = 1'b1;
        out_q.delete();
        wait_cycles(5);
        flush = 1'b1;
        wait_cycles(1);
        flush = 1'b0;
        wait_cycles(20);
        checks++;
        if (out_q.size() != 0 || m_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_empty: got %0d bytes valid=%0b busy=%0b, want none", out_q.size(), m_valid, busy);
        end
        send_byte(c, 1'b0);
        wait_cycles(20);
        checks++;
        if (out_q.size() != 0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL flush_not_sticky: got %0d bytes busy=%0b, want 0 bytes busy=1", out_q.size(), busy);
        end
        flush = 1'b1;
        wait_cycles(1);
        flush = 1'b0;
        wait_cycles(5);
        exp_pkts++;
        checks++;
        if (out_q.size() != 1 || out_q[0] !== {1'b1, c} || pkt_count !== 16'(exp_pkts)) begin
            fails++;
            $display("FAIL flush_after_empty: got %0d bytes pkts=%0d, want 1 byte %03h pkts=%0d",
                     out_q.size(), pkt_count, {1'b1, c}, exp_pkts);
        end
    endtask

    task automatic test_random_mix();
        bit done = 1'b0;
        hs = 1'($urandom);
        prep_stream(400, 16);
        build_model(hs);
        fork
            begin
                drive_stream();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock);
                    #1;
                    m_ready = ($urandom_range(0, 3) != 0);
                end
                m_ready = 1'b1;
            end
        join
        wait_cycles(TO + 20);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL mix_len: got %0d bytes, want %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL mix_byte %0d: got %03h want %03h", i + 1, out_q[i], exp_q[i]);
            end
        end
        checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            fails++;
            $display("FAIL mix_pkts: got %0d want %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_reset_mid();
        hs = 1'b1;
        m_ready = 1'b1;
        prep_stream(10, 0);
        drive_stream();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'($urandom);
        wait_cycles(3);
        checks++;
        if (m_valid !== 1'b1 || m_data !== in_data[9]) begin
            fails++;
            $display("FAIL mid_released: valid=%0b data=%02h, want 1 %02h", m_valid, m_data, in_data[9]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, m_valid, m_last, busy} !== 4'b0000 || m_data !== 8'h00 || pkt_count !== 16'h0) begin
            fails++;
            $display("FAIL mid_reset: ready=%0b valid=%0b last=%0b busy=%0b data=%02h pkts=%0d, want all 0",
                     s_ready, m_valid, m_last, busy, m_data, pkt_count);
        end
        s_valid = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        exp_pkts = 0;
        wait_cycles(2);
        hs = 1'b0;
        m_ready = 1'b1;
        prep_stream(64, 0);
        build_model(1'b0);
        drive_stream();
        wait_cycles(20);
        checks++;
        if (out_q.size() != 64) begin
            fails++;
            $display("FAIL post_reset_len: got %0d bytes, want 64", out_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL post_reset_byte %0d: got %03h want %03h", i + 1, out_q[i], exp_q[i]);
            end
        end
        checks++;
        if (pkt_count !== 16'd1) begin
            fails++;
            $display("FAIL post_reset_pkts: got %0d want 1", pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_hs_stream();
        test_fs_stream();
        test_upstream_last();
        test_flush();
        test_stall();
        test_flush_empty();
        test_random_mix();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
